// File: rtl/cc_pkg.sv
// Shared cache-controller constants and types for the lookup dispatch path.
package cc_pkg;
   localparam int CC_LINE_W     = 512;
   localparam int CC_OFFSET_W   = 6;
   localparam int CC_HIT_DATA_W = CC_OFFSET_W + CC_LINE_W;

   localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
   localparam logic [3:0] CC_ARLEN       = 4'd7;
   localparam logic [2:0] CC_ARSIZE      = 3'd3;

   typedef enum logic {
      CC_IDLE,
      CC_AR_WAIT
   } cc_disp_state_t;
endpackage

// File: rtl/cc_outstanding_counter.sv
// Saturating up/down count of misses in flight, with a below-limit flag.
module cc_outstanding_counter #(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [3:0] count_o,
   output logic       below_limit_o
);
   logic [3:0] count_q, count_d;

   // A simultaneous issue and retire leaves the count unchanged.
   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q < 4'(MAX_OUTSTANDING)))
         count_d = count_q + 4'd1;
      else if (dec_i && !inc_i && (count_q != 4'd0))
         count_d = count_q - 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= 4'd0;
      else     count_q <= count_d;
   end

   assign count_o       = count_q;
   assign below_limit_o = (count_q < 4'(MAX_OUTSTANDING));

   // A last R beat with nothing outstanding means the memory side is confused.
   assert property (@(posedge clk) disable iff (rst) dec_i |-> (count_q != 4'd0));
endmodule

// File: rtl/cc_lookup_dispatch_unit.sv
// Routes tag-lookup results: flag for every result, line data for hits, wrap burst for misses.
module cc_lookup_dispatch_unit
   import cc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 8,
   parameter int ADDR_W          = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lookup_valid_i,
   output logic                     lookup_ready_o,
   input  logic                     lookup_hit_i,
   input  logic [ADDR_W-1:0]        lookup_addr_i,
   input  logic [CC_LINE_W-1:0]     lookup_data_i,
   input  logic                     hit_flag_fifo_afull_i,
   output logic                     hit_flag_fifo_wren_o,
   output logic                     hit_flag_fifo_wdata_o,
   input  logic                     hit_data_fifo_afull_i,
   output logic                     hit_data_fifo_wren_o,
   output logic [CC_HIT_DATA_W-1:0] hit_data_fifo_wdata_o,
   output logic [ADDR_W-1:0]        mem_araddr_o,
   output logic [3:0]               mem_arlen_o,
   output logic [2:0]               mem_arsize_o,
   output logic [1:0]               mem_arburst_o,
   output logic                     mem_arvalid_o,
   input  logic                     mem_arready_i,
   input  logic                     mem_rvalid_i,
   input  logic                     mem_rready_i,
   input  logic                     mem_rlast_i
);
   cc_disp_state_t    state_q, state_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              miss_accept;
   logic              retire;
   logic              below_limit;
   logic [3:0]        outstanding;

   assign retire = mem_rvalid_i & mem_rready_i & mem_rlast_i;

   cc_outstanding_counter #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_outstanding (
      .clk          (clk),
      .rst          (rst),
      .inc_i        (miss_accept),
      .dec_i        (retire),
      .count_o      (outstanding),
      .below_limit_o(below_limit)
   );

   // Ready is held low during reset so no strobe can escape while rst is high.
   always_comb begin
      state_d              = state_q;
      araddr_d             = araddr_q;
      lookup_ready_o       = 1'b0;
      hit_flag_fifo_wren_o = 1'b0;
      hit_data_fifo_wren_o = 1'b0;
      miss_accept          = 1'b0;
      unique case (state_q)
         CC_IDLE: begin
            lookup_ready_o = !rst && !hit_flag_fifo_afull_i &&
                             (lookup_hit_i ? !hit_data_fifo_afull_i : below_limit);
            if (lookup_valid_i && lookup_ready_o) begin
               hit_flag_fifo_wren_o = 1'b1;
               if (lookup_hit_i) begin
                  hit_data_fifo_wren_o = 1'b1;
               end else begin
                  miss_accept = 1'b1;
                  araddr_d    = {lookup_addr_i[ADDR_W-1:3], 3'b000};
                  state_d     = CC_AR_WAIT;
               end
            end
         end
         CC_AR_WAIT: begin
            if (mem_arready_i) state_d = CC_IDLE;
         end
         default: state_d = CC_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= CC_IDLE;
         araddr_q <= '0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
      end
   end

   assign hit_flag_fifo_wdata_o = lookup_hit_i;
   assign hit_data_fifo_wdata_o = {lookup_addr_i[CC_OFFSET_W-1:0], lookup_data_i};
   assign mem_arvalid_o         = (state_q == CC_AR_WAIT);
   assign mem_araddr_o          = araddr_q;
   assign mem_arlen_o           = CC_ARLEN;
   assign mem_arsize_o          = CC_ARSIZE;
   assign mem_arburst_o         = AXI_BURST_WRAP;
endmodule

// File: tb/tb_cc_lookup_dispatch_unit.sv
// Scoreboard bench for cc_lookup_dispatch_unit with a two-miss outstanding limit.
module tb_cc_lookup_dispatch_unit;
   localparam int ADDR_W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          lookup_valid_i = 1'b0;
   logic          lookup_ready_o;
   logic          lookup_hit_i = 1'b0;
   logic [31:0]   lookup_addr_i = '0;
   logic [511:0]  lookup_data_i = '0;
   logic          hit_flag_fifo_afull_i = 1'b0;
   logic          hit_flag_fifo_wren_o;
   logic          hit_flag_fifo_wdata_o;
   logic          hit_data_fifo_afull_i = 1'b0;
   logic          hit_data_fifo_wren_o;
   logic [517:0]  hit_data_fifo_wdata_o;
   logic [31:0]   mem_araddr_o;
   logic [3:0]    mem_arlen_o;
   logic [2:0]    mem_arsize_o;
   logic [1:0]    mem_arburst_o;
   logic          mem_arvalid_o;
   logic          mem_arready_i = 1'b1;
   logic          mem_rvalid_i = 1'b0;
   logic          mem_rready_i = 1'b0;
   logic          mem_rlast_i = 1'b0;

   int total = 0;
   int bad   = 0;

   logic         exp_flag[$];
   logic [517:0] exp_data[$];
   logic [31:0]  exp_ar[$];

   cc_lookup_dispatch_unit #(.MAX_OUTSTANDING(2), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
      .lookup_hit_i(lookup_hit_i), .lookup_addr_i(lookup_addr_i), .lookup_data_i(lookup_data_i),
      .hit_flag_fifo_afull_i(hit_flag_fifo_afull_i), .hit_flag_fifo_wren_o(hit_flag_fifo_wren_o),
      .hit_flag_fifo_wdata_o(hit_flag_fifo_wdata_o),
      .hit_data_fifo_afull_i(hit_data_fifo_afull_i), .hit_data_fifo_wren_o(hit_data_fifo_wren_o),
      .hit_data_fifo_wdata_o(hit_data_fifo_wdata_o),
      .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o), .mem_arsize_o(mem_arsize_o),
      .mem_arburst_o(mem_arburst_o), .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rready_i(mem_rready_i), .mem_rlast_i(mem_rlast_i)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a write or an AR handshake.
   logic [517:0] m_exp_d;
   logic [31:0]  m_exp_a;
   logic         m_exp_f;
   always @(negedge clk) begin
      if (!rst) begin
         if (hit_flag_fifo_wren_o) begin
            if (exp_flag.size() == 0) chk("flag_unexpected", 64'd1, 64'd0);
            else begin
               m_exp_f = exp_flag.pop_front();
               chk("flag_wdata", 64'(hit_flag_fifo_wdata_o), 64'(m_exp_f));
               $display("txn flag=%0d t=%0t", hit_flag_fifo_wdata_o, $time);
            end
         end
         if (hit_data_fifo_wren_o) begin
            if (exp_data.size() == 0) chk("data_unexpected", 64'd1, 64'd0);
            else begin
               m_exp_d = exp_data.pop_front();
               total++;
               if (hit_data_fifo_wdata_o !== m_exp_d) begin
                  bad++;
                  $display("FAIL data_wdata: got %h expected %h", hit_data_fifo_wdata_o, m_exp_d);
               end
               $display("txn data off=%0h t=%0t", hit_data_fifo_wdata_o[517:512], $time);
            end
         end
         if (mem_arvalid_o && mem_arready_i) begin
            if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
            else begin
               m_exp_a = exp_ar.pop_front();
               chk("araddr", 64'(mem_araddr_o), 64'(m_exp_a));
               chk("arlen", 64'(mem_arlen_o), 64'd7);
               chk("arsize", 64'(mem_arsize_o), 64'd3);
               chk("arburst", 64'(mem_arburst_o), 64'd2);
               $display("txn ar addr=%0h t=%0t", mem_araddr_o, $time);
            end
         end
      end
   end

   task automatic do_lookup(input logic hit, input logic [31:0] addr, input logic [511:0] data);
      int n = 0;
      lookup_valid_i = 1'b1;
      lookup_hit_i   = hit;
      lookup_addr_i  = addr;
      lookup_data_i  = data;
      exp_flag.push_back(hit);
      if (hit) exp_data.push_back({addr[5:0], data});
      else     exp_ar.push_back({addr[31:3], 3'b000});
      @(negedge clk);
      while (!lookup_ready_o && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!lookup_ready_o) chk("accept_timeout", 64'(lookup_ready_o), 64'd1);
      @(posedge clk); #1;
      lookup_valid_i = 1'b0;
   endtask

   task automatic retire_one();
      mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
   endtask

   logic [511:0] pat;

   initial begin
      pat = {8{64'hDEAD_BEEF_0123_4567}};
      // Reset: nothing escapes while rst is high, even with a valid lookup presented.
      rst = 1'b1;
      lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_addr_i = 32'h1028;
      #12;
      chk("rst_ready", 64'(lookup_ready_o), 64'd0);
      chk("rst_flag_wren", 64'(hit_flag_fifo_wren_o), 64'd0);
      chk("rst_data_wren", 64'(hit_data_fifo_wren_o), 64'd0);
      chk("rst_arvalid", 64'(mem_arvalid_o), 64'd0);
      chk("rst_araddr", 64'(mem_araddr_o), 64'd0);
      lookup_valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Single hit.
      do_lookup(1'b1, 32'h1028, pat);
      @(negedge clk);
      chk("hit_no_ar", 64'(mem_arvalid_o), 64'd0);

      // Single miss with arready held low for 3 cycles.
      @(posedge clk); #1;
      mem_arready_i = 1'b0;
      do_lookup(1'b0, 32'h2034, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arw_arvalid", 64'(mem_arvalid_o), 64'd1);
         chk("arw_araddr", 64'(mem_araddr_o), 64'h2030);
         chk("arw_ready", 64'(lookup_ready_o), 64'd0);
      end
      @(posedge clk); #1;
      mem_arready_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("arw_done_arvalid", 64'(mem_arvalid_o), 64'd0);
      chk("arw_done_ready", 64'(lookup_ready_o), 64'd1);

      // Outstanding limit of 2: third miss stalls until a retire.
      @(posedge clk); #1;
      retire_one();
      do_lookup(1'b0, 32'h3000, '0);
      do_lookup(1'b0, 32'h3100, '0);
      lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = 32'h320F;
      exp_flag.push_back(1'b0); exp_ar.push_back(32'h3208);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("limit_stall", 64'(lookup_ready_o), 64'd0);
      end
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
      @(negedge clk);
      chk("limit_retire_cycle", 64'(lookup_ready_o), 64'd0);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
      @(negedge clk);
      chk("limit_release", 64'(lookup_ready_o), 64'd1);
      @(posedge clk); #1;
      lookup_valid_i = 1'b0;
      retire_one();
      retire_one();

      // Flag FIFO almost full blocks everything; order H,M,H,H on release.
      hit_flag_fifo_afull_i = 1'b1;
      lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_addr_i = 32'h4000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("afull_ready", 64'(lookup_ready_o), 64'd0);
         chk("afull_flag_wren", 64'(hit_flag_fifo_wren_o), 64'd0);
         chk("afull_data_wren", 64'(hit_data_fifo_wren_o), 64'd0);
         lookup_hit_i = ~lookup_hit_i;
      end
      @(posedge clk); #1;
      lookup_valid_i = 1'b0;
      hit_flag_fifo_afull_i = 1'b0;
      do_lookup(1'b1, 32'h4001, ~pat);
      do_lookup(1'b0, 32'h4042, '0);
      do_lookup(1'b1, 32'h4083, pat ^ {16{32'h5A5A_5A5A}});
      do_lookup(1'b1, 32'h40FF, {16{32'h1357_9BDF}});
      // Data FIFO almost full only blocks hits.
      hit_data_fifo_afull_i = 1'b1;
      lookup_hit_i = 1'b1;
      @(negedge clk);
      chk("dafull_hit_ready", 64'(lookup_ready_o), 64'd0);
      lookup_hit_i = 1'b0;
      #1;
      chk("dafull_miss_ready", 64'(lookup_ready_o), 64'd1);
      @(posedge clk); #1;
      hit_data_fifo_afull_i = 1'b0;
      retire_one();

      // Miss accepted in the same cycle as a retire with count at 1.
      do_lookup(1'b0, 32'h5010, '0);
      @(posedge clk); #1;
      lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = 32'h5020;
      exp_flag.push_back(1'b0); exp_ar.push_back(32'h5020);
      mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
      @(negedge clk);
      chk("simul_ready", 64'(lookup_ready_o), 64'd1);
      @(posedge clk); #1;
      lookup_valid_i = 1'b0;
      mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
      do_lookup(1'b0, 32'h5030, '0);
      @(posedge clk); #1;
      lookup_hit_i = 1'b0;
      @(negedge clk);
      chk("simul_idle", 64'(mem_arvalid_o), 64'd0);
      chk("simul_count_full", 64'(lookup_ready_o), 64'd0);
      @(posedge clk); #1;
      retire_one();
      retire_one();

      // Reset during AR_WAIT.
      mem_arready_i = 1'b0;
      do_lookup(1'b0, 32'h6008, '0);
      @(negedge clk);
      chk("pre_rst_arvalid", 64'(mem_arvalid_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_arvalid", 64'(mem_arvalid_o), 64'd0);
      chk("async_rst_araddr", 64'(mem_araddr_o), 64'd0);
      chk("async_rst_ready", 64'(lookup_ready_o), 64'd0);
      exp_ar.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      mem_arready_i = 1'b1;
      do_lookup(1'b0, 32'h7000, '0);
      do_lookup(1'b0, 32'h7040, '0);
      @(posedge clk); #1;
      lookup_hit_i = 1'b0;
      @(negedge clk);
      chk("post_rst_count_full", 64'(lookup_ready_o), 64'd0);
      @(posedge clk); #1;
      retire_one();
      retire_one();
      repeat (2) @(posedge clk);

      chk("flag_queue_empty", 64'(exp_flag.size()), 64'd0);
      chk("data_queue_empty", 64'(exp_data.size()), 64'd0);
      chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/cc_lookup_dispatch_unit.md
# cc_lookup_dispatch_unit

- Writer-side counterpart of the cache controller's data reorder path.
- Per tag-lookup result, pushes one order flag into the hit-flag FIFO.
- Hits: pushes `{offset, line}` into the hit-data FIFO.
- Misses: issues one AXI wrap read burst to memory.
- Throttles lookups on FIFO almost-full and on the outstanding-miss limit, so the reorder side always sees a flag before its data.

## Interface
Parameters:
- MAX_OUTSTANDING, 8, maximum misses with AR issued whose last R beat has not been seen (1..15).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_valid_i  in  1  lookup result valid.
- lookup_ready_o  out  1  result accepted when valid & ready.
- lookup_hit_i  in  1  1 = hit, 0 = miss.
- lookup_addr_i  in  ADDR_W  request byte address.
- lookup_data_i  in  512  cache line; meaningful on hit only.
- hit_flag_fifo_afull_i  in  1  flag FIFO almost full.
- hit_flag_fifo_wren_o  out  1  flag FIFO write strobe.
- hit_flag_fifo_wdata_o  out  1  flag (1 = hit).
- hit_data_fifo_afull_i  in  1  data FIFO almost full.
- hit_data_fifo_wren_o  out  1  data FIFO write strobe.
- hit_data_fifo_wdata_o  out  518  {addr[5:0], line[511:0]}.
- mem_araddr_o  out  ADDR_W  burst address.
- mem_arlen_o  out  4  constant 7.
- mem_arsize_o  out  3  constant 3 (8 bytes).
- mem_arburst_o  out  2  constant 2'b10 (WRAP).
- mem_arvalid_o  out  1  AR valid.
- mem_arready_i  in  1  AR ready.
- mem_rvalid_i, mem_rready_i, mem_rlast_i  in  1 each  monitored R handshake, used to retire misses.

## Operation
- States: IDLE, AR_WAIT.
- lookup_ready_o = IDLE & !hit_flag_fifo_afull_i & (lookup_hit_i ? !hit_data_fifo_afull_i : outstanding < MAX_OUTSTANDING).
- Accept, same cycle:
  - hit_flag_fifo_wren_o = 1.
  - wdata = lookup_hit_i.
- Hit accept:
  - hit_data_fifo_wren_o = 1.
  - wdata = {lookup_addr_i[5:0], lookup_data_i}.
  - State stays IDLE.
- Miss accept:
  - Register araddr = {lookup_addr_i[ADDR_W-1:3], 3'b000} (critical word first).
  - outstanding += 1.
  - Go to AR_WAIT.
- AR_WAIT:
  - mem_arvalid_o = 1; araddr held stable.
  - On mem_arready_i, go to IDLE.
  - lookup_ready_o = 0 throughout.
- Retire: outstanding -= 1 on mem_rvalid_i & mem_rready_i & mem_rlast_i.
- Simultaneous miss accept and retire: count unchanged.
- outstanding is 4 bits; never exceeds MAX_OUTSTANDING and never underflows. A retire at 0 is an assertion error.
- No write strobe without an accept; strobes never fire in AR_WAIT.

## Timing
- Reset values:
  - state IDLE, outstanding 0.
  - mem_arvalid_o 0, mem_araddr_o 0.
  - All wren 0, lookup_ready_o 0 while rst is high.
- FIFO writes are combinational with the accept (0-cycle latency). The FIFOs' afull thresholds absorb the 1-cycle afull lag.
- mem_arvalid_o rises the cycle after a miss accept. A zero-wait arready_i makes it a 1-cycle pulse, and the next lookup is accepted the cycle after that.
- Back-to-back hits: one per cycle. Back-to-back misses: one per 2 cycles minimum.
- afull asserted: ready drops the same cycle; no write strobe in that cycle.
- Reset mid-burst: arvalid drops asynchronously and the count clears. The whole controller resets together.

## Structure
- Shared package cc_pkg holds:
  - CC_LINE_W = 512, CC_OFFSET_W = 6, CC_HIT_DATA_W = 518.
  - AXI_BURST_WRAP = 2'b10, CC_ARLEN = 4'd7, CC_ARSIZE = 3'd3.
  - State enum cc_disp_state_t.
- One natural sub-module: cc_outstanding_counter (saturating up/down counter with a below-limit flag).

## Test plan
- Single hit, addr 0x1028, data pattern: flag wren with wdata 1; data wdata[517:512] = 6'h28; no AR.
- Single miss, addr 0x2034: flag wdata 0; next cycle arvalid with araddr 0x2030, arlen 7, arburst 2'b10; arready held low 3 cycles → araddr stable, ready 0 throughout.
- MAX_OUTSTANDING = 2, three misses, no R beats: third miss stalls (ready 0) until one rlast handshake; accepted the cycle after.
- hit_flag_fifo_afull_i high during a hit/miss stream → no wren; resume on deassert; flag order matches input order (H,M,H,H).
- Miss accepted in the same cycle as an rlast retire, count at 1 → count stays 1.
- Assert rst during AR_WAIT → arvalid 0 immediately, count 0; next lookup accepted normally after release.
